nn_weight_loader: RTL and testbench



---
 rtl/nn_weight_loader_pkg.sv | 16 +
 rtl/nn_loader_index_ctr.sv | 81 ++++++++
 rtl/nn_weight_loader.sv | 165 ++++++++++++++++
 tb/tb_nn_weight_loader.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_weight_loader_pkg.sv
// Shared definitions for the weight loader: FSM encoding, layer count, word width.
package nn_weight_loader_pkg;

  localparam int NUM_LAYERS = 4;
  localparam int WORD_W     = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD_W = 2'd1,
    ST_LOAD_B = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/nn_loader_index_ctr.sv
// Nested layer/neuron/weight index counter; limits for the current layer come from a combinational mux.
module nn_loader_index_ctr
  import nn_weight_loader_pkg::*;
#(
  parameter int NEURONS_L1 = 30,
  parameter int NEURONS_L2 = 30,
  parameter int NEURONS_L3 = 10,
  parameter int NEURONS_L4 = 10,
  parameter int WEIGHTS_L1 = 784,
  parameter int WEIGHTS_L2 = 30,
  parameter int WEIGHTS_L3 = 30,
  parameter int WEIGHTS_L4 = 10
) (
  input  logic        s_axi_aclk,
  input  logic        reset,
  input  logic        clear,
  input  logic        step_weight,
  input  logic        advance,
  output logic [2:0]  layer,
  output word_t       neuron,
  output logic        last_weight,
  output logic        last_neuron,
  output logic        last_layer
);

  logic [2:0] layer_reg;
  word_t      neuron_reg;
  word_t      widx_reg;
  word_t      neuron_max;
  word_t      weight_max;

  always_comb begin
    neuron_max = word_t'(NEURONS_L1 - 1);
    weight_max = word_t'(WEIGHTS_L1 - 1);
    case (layer_reg)
      3'd2: begin
        neuron_max = word_t'(NEURONS_L2 - 1);
        weight_max = word_t'(WEIGHTS_L2 - 1);
      end
      3'd3: begin
        neuron_max = word_t'(NEURONS_L3 - 1);
        weight_max = word_t'(WEIGHTS_L3 - 1);
      end
      3'd4: begin
        neuron_max = word_t'(NEURONS_L4 - 1);
        weight_max = word_t'(WEIGHTS_L4 - 1);
      end
      default: ;
    endcase
  end

  assign last_weight = (widx_reg == weight_max);
  assign last_neuron = (neuron_reg == neuron_max);
  assign last_layer  = (layer_reg == 3'(NUM_LAYERS));
  assign layer       = layer_reg;
  assign neuron      = neuron_reg;

  // Advancing past the final neuron of the final layer holds the indices; the FSM leaves the load.
  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      layer_reg  <= 3'd0;
      neuron_reg <= '0;
      widx_reg   <= '0;
    end else if (clear) begin
      layer_reg  <= 3'd1;
      neuron_reg <= '0;
      widx_reg   <= '0;
    end else if (advance) begin
      widx_reg <= '0;
      if (!last_neuron) begin
        neuron_reg <= neuron_reg + word_t'(1);
      end else if (!last_layer) begin
        layer_reg  <= layer_reg + 3'd1;
        neuron_reg <= '0;
      end
    end else if (step_weight) begin
      widx_reg <= widx_reg + word_t'(1);
    end
  end

endmodule

// File: rtl/nn_weight_loader.sv
// Stream-driven weight/bias sequencer for the 4-layer network.
// Define BIAS_LOAD_EN to make each neuron consume one extra word as its bias.
module nn_weight_loader
  import nn_weight_loader_pkg::*;
#(
  parameter int NEURONS_L1 = 30,
  parameter int NEURONS_L2 = 30,
  parameter int NEURONS_L3 = 10,
  parameter int NEURONS_L4 = 10,
  parameter int WEIGHTS_L1 = 784,
  parameter int WEIGHTS_L2 = 30,
  parameter int WEIGHTS_L3 = 30,
  parameter int WEIGHTS_L4 = 10
) (
  input  logic              s_axi_aclk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [WORD_W-1:0] weightValue,
  output logic              weightValid,
  output logic [WORD_W-1:0] biasValue,
  output logic              biasValid,
  output logic [WORD_W-1:0] config_layer_num,
  output logic [WORD_W-1:0] config_neuron_num,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [WORD_W-1:0] word_count
);

`ifdef BIAS_LOAD_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  state_t     state_reg;
  state_t     state_next;
  logic       loading;
  logic       hs;
  logic       clear;
  logic       step_weight;
  logic       advance;
  logic [2:0] layer;
  word_t      neuron;
  logic       last_weight;
  logic       last_neuron;
  logic       last_layer;

  word_t      weight_value_reg;
  logic       weight_valid_reg;
  word_t      layer_num_reg;
  word_t      neuron_num_reg;
  logic       aborted_reg;
  word_t      word_count_reg;

  nn_loader_index_ctr #(
    .NEURONS_L1(NEURONS_L1), .NEURONS_L2(NEURONS_L2),
    .NEURONS_L3(NEURONS_L3), .NEURONS_L4(NEURONS_L4),
    .WEIGHTS_L1(WEIGHTS_L1), .WEIGHTS_L2(WEIGHTS_L2),
    .WEIGHTS_L3(WEIGHTS_L3), .WEIGHTS_L4(WEIGHTS_L4)
  ) u_index_ctr (
    .s_axi_aclk (s_axi_aclk),
    .reset      (reset),
    .clear      (clear),
    .step_weight(step_weight),
    .advance    (advance),
    .layer      (layer),
    .neuron     (neuron),
    .last_weight(last_weight),
    .last_neuron(last_neuron),
    .last_layer (last_layer)
  );

  always_ff @(posedge s_axi_aclk) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Abort overrides the handshake's successor state; the word itself is still delivered.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = ST_LOAD_W;
      ST_LOAD_W: begin
        if (hs && last_weight) begin
          if (BIAS_EN)                        state_next = ST_LOAD_B;
          else if (last_neuron && last_layer) state_next = ST_DONE;
        end
        if (abort) state_next = ST_IDLE;
      end
      ST_LOAD_B: begin
        if (hs) state_next = (last_neuron && last_layer) ? ST_DONE : ST_LOAD_W;
        if (abort) state_next = ST_IDLE;
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    loading     = (state_reg == ST_LOAD_W) || (state_reg == ST_LOAD_B);
    in_ready    = loading;
    busy        = (state_reg != ST_IDLE);
    done        = (state_reg == ST_DONE);
    hs          = in_valid && loading;
    clear       = (state_reg == ST_IDLE) && start;
    step_weight = hs && (state_reg == ST_LOAD_W) && !last_weight;
    advance     = hs && ((state_reg == ST_LOAD_B) ||
                         ((state_reg == ST_LOAD_W) && last_weight && !BIAS_EN));
  end

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      weight_value_reg <= '0;
      weight_valid_reg <= 1'b0;
      layer_num_reg    <= '0;
      neuron_num_reg   <= '0;
      aborted_reg      <= 1'b0;
      word_count_reg   <= '0;
    end else begin
      weight_valid_reg <= hs && (state_reg == ST_LOAD_W);
      aborted_reg      <= loading && abort;
      if (hs) begin
        layer_num_reg  <= word_t'(layer);
        neuron_num_reg <= neuron;
      end
      if (hs && (state_reg == ST_LOAD_W)) weight_value_reg <= in_data;
      if (clear)                               word_count_reg <= '0;
      else if (hs && (word_count_reg != '1))   word_count_reg <= word_count_reg + word_t'(1);
    end
  end

`ifdef BIAS_LOAD_EN
  word_t bias_value_reg;
  logic  bias_valid_reg;

  always_ff @(posedge s_axi_aclk) begin
    if (reset) begin
      bias_value_reg <= '0;
      bias_valid_reg <= 1'b0;
    end else begin
      bias_valid_reg <= hs && (state_reg == ST_LOAD_B);
      if (hs && (state_reg == ST_LOAD_B)) bias_value_reg <= in_data;
    end
  end

  assign biasValue = bias_value_reg;
  assign biasValid = bias_valid_reg;
`else
  assign biasValue = '0;
  assign biasValid = 1'b0;
`endif

  assign weightValue       = weight_value_reg;
  assign weightValid       = weight_valid_reg;
  assign config_layer_num  = layer_num_reg;
  assign config_neuron_num = neuron_num_reg;
  assign aborted           = aborted_reg;
  assign word_count        = word_count_reg;

endmodule

// File: tb/tb_nn_weight_loader.sv
// Directed bench for nn_weight_loader with a per-cycle reference model of the load order.
module tb_nn_weight_loader;

  localparam int NEU [4] = '{2, 2, 1, 1};
  localparam int WGT [4] = '{3, 2, 2, 1};
`ifdef BIAS_LOAD_EN
  localparam int TOTAL_LIT = 19;
`else
  localparam int TOTAL_LIT = 13;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] weightValue, biasValue, config_layer_num, config_neuron_num, word_count;
  logic        weightValid, biasValid, busy, done, aborted;

  always #5 clk = ~clk;

  nn_weight_loader #(
    .NEURONS_L1(NEU[0]), .NEURONS_L2(NEU[1]), .NEURONS_L3(NEU[2]), .NEURONS_L4(NEU[3]),
    .WEIGHTS_L1(WGT[0]), .WEIGHTS_L2(WGT[1]), .WEIGHTS_L3(WGT[2]), .WEIGHTS_L4(WGT[3])
  ) dut (
    .s_axi_aclk(clk), .reset(reset), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .weightValue(weightValue), .weightValid(weightValid),
    .biasValue(biasValue), .biasValid(biasValid),
    .config_layer_num(config_layer_num), .config_neuron_num(config_neuron_num),
    .busy(busy), .done(done), .aborted(aborted), .word_count(word_count)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected target of every word in load order, built from the nested-loop rule.
  bit t_bias[$];
  int t_layer[$];
  int t_neuron[$];
  int total;

  task automatic build_model();
    for (int l = 0; l < 4; l++)
      for (int n = 0; n < NEU[l]; n++) begin
        for (int w = 0; w < WGT[l]; w++) begin
          t_bias.push_back(1'b0); t_layer.push_back(l + 1); t_neuron.push_back(n);
        end
`ifdef BIAS_LOAD_EN
        t_bias.push_back(1'b1); t_layer.push_back(l + 1); t_neuron.push_back(n);
`endif
      end
    total = t_bias.size();
  endtask

  // Model state: phase 0 idle, 1 loading, 2 done.
  bit          chk_en = 1'b0;
  int          m_phase = 0;
  int          m_idx = 0;
  logic [31:0] m_count = '0;
  bit          e_wv = 0, e_bv = 0, e_done = 0, e_abt = 0;
  logic [31:0] e_val = '0;
  int          e_layer = 0, e_neuron = 0;

  logic [31:0] obs_val[$];
  bit          obs_bias[$];
  int          obs_layer[$];
  int          obs_neuron[$];
  int          n_done = 0, n_abt = 0, done_at = -1;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("weightValid", weightValid, e_wv);
      chk("biasValid", biasValid, e_bv);
      if (e_wv) chk("weightValue", weightValue, e_val);
      if (e_bv) chk("biasValue", biasValue, e_val);
      if (e_wv || e_bv) begin
        chk("config_layer_num", config_layer_num, e_layer);
        chk("config_neuron_num", config_neuron_num, e_neuron);
      end
      chk("done", done, e_done);
      chk("aborted", aborted, e_abt);
      chk("busy", busy, m_phase != 0);
      chk("in_ready", in_ready, m_phase == 1);
      chk("word_count", word_count, m_count);
`ifndef BIAS_LOAD_EN
      chk("biasValue_tied", biasValue, 0);
`endif
      if (weightValid || biasValid) begin
        obs_val.push_back(biasValid ? biasValue : weightValue);
        obs_bias.push_back(biasValid);
        obs_layer.push_back(int'(config_layer_num));
        obs_neuron.push_back(int'(config_neuron_num));
        $display("strobe %0d: %s 0x%0h -> L%0d N%0d", obs_val.size(),
                 biasValid ? "bias" : "weight", obs_val[$], config_layer_num, config_neuron_num);
      end
      if (done) begin n_done++; done_at = obs_val.size(); end
      if (aborted) n_abt++;

      e_wv = 0; e_bv = 0; e_done = 0; e_abt = 0;
      if (reset) begin
        m_phase = 0; m_idx = 0; m_count = '0;
      end else begin
        case (m_phase)
          0: if (start) begin m_phase = 1; m_idx = 0; m_count = '0; end
          1: begin
            if (in_valid) begin
              if (m_idx < total) begin
                e_bv = t_bias[m_idx]; e_wv = !e_bv; e_val = in_data;
                e_layer = t_layer[m_idx]; e_neuron = t_neuron[m_idx];
                m_idx++;
              end
              if (m_count != 32'hFFFF_FFFF) m_count++;
            end
            if (abort) begin m_phase = 0; e_abt = 1; end
            else if (in_valid && m_idx == total) begin m_phase = 2; e_done = 1; end
          end
          default: m_phase = 0;
        endcase
      end
    end
  end

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic clear_obs();
    obs_val.delete(); obs_bias.delete(); obs_layer.delete(); obs_neuron.delete();
    n_done = 0; n_abt = 0; done_at = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cycle(); start = 1'b0;
  endtask

  // Offers words base+k until n are accepted; abort_at/start_at pulse alongside word k.
  task automatic stream(input int n, input int base, input bit gapped,
                        input int abort_at, input int start_at, output int got);
    int k = 0;
    int cyc = 0;
    bit hs, stop;
    stop = 0;
    while (k < n && cyc < 2000 && !stop) begin
      in_valid = gapped ? 1'($urandom_range(1)) : 1'b1;
      in_data  = base + k;
      abort    = (abort_at == k) && in_valid;
      start    = (start_at == k);
      @(negedge clk);
      hs = in_valid && in_ready;
      if (hs && abort) stop = 1;
      cycle();
      if (hs) k++;
      cyc++;
      abort = 1'b0; start = 1'b0;
    end
    in_valid = 1'b0;
    got = k;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    build_model();

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    chk("reset_weightValue", weightValue, 0);
    chk("reset_layer", config_layer_num, 0);
    chk("reset_busy", busy, 0);
    chk("reset_word_count", word_count, 0);
    cycle();

    // Full load, continuous valid; start during DONE must be ignored.
    clear_obs();
    pulse_start();
    stream(total, 32'h100, 0, -1, -1, got);
    chk("t1_words", got, TOTAL_LIT);
    start = 1'b1; cycle(); start = 1'b0;
    repeat (3) cycle();
    chk("t1_strobes", obs_val.size(), TOTAL_LIT);
    chk("t1_first_val", obs_val[0], 32'h100);
    chk("t1_first_layer", obs_layer[0], 1);
    chk("t1_first_neuron", obs_neuron[0], 0);
`ifdef BIAS_LOAD_EN
    chk("t1_fourth_bias", obs_bias[3], 1);
    chk("t1_fourth_val", obs_val[3], 32'h103);
    chk("t1_last_bias", obs_bias[TOTAL_LIT-1], 1);
`endif
    chk("t1_last_val", obs_val[TOTAL_LIT-1], 32'h100 + TOTAL_LIT - 1);
    chk("t1_last_layer", obs_layer[TOTAL_LIT-1], 4);
    chk("t1_last_neuron", obs_neuron[TOTAL_LIT-1], 0);
    chk("t1_done_count", n_done, 1);
    chk("t1_done_with_last", done_at, TOTAL_LIT);
    chk("t1_word_count", word_count, TOTAL_LIT);
    chk("t1_idle_after", busy, 0);

    // Gapped valid: same order and targets.
    clear_obs();
    pulse_start();
    stream(total, 32'h500, 1, -1, -1, got);
    repeat (3) cycle();
    chk("t2_words", got, TOTAL_LIT);
    chk("t2_strobes", obs_val.size(), TOTAL_LIT);
    chk("t2_done_count", n_done, 1);

    // Abort after 5 words, then restart from L1N0.
    clear_obs();
    pulse_start();
    stream(5, 32'h200, 0, -1, -1, got);
    abort = 1'b1; cycle(); abort = 1'b0;
    repeat (3) cycle();
    chk("t3_aborted", n_abt, 1);
    chk("t3_no_done", n_done, 0);
    chk("t3_word_count", word_count, 5);
    chk("t3_idle", busy, 0);
    clear_obs();
    pulse_start();
    stream(total, 32'h600, 0, -1, -1, got);
    repeat (3) cycle();
    chk("t3_restart_layer", obs_layer[0], 1);
    chk("t3_restart_neuron", obs_neuron[0], 0);
    chk("t3_restart_done", n_done, 1);

    // Abort in the same cycle as the 5th handshake.
    clear_obs();
    pulse_start();
    stream(10, 32'h300, 0, 4, -1, got);
    repeat (3) cycle();
    chk("t4_words", got, 5);
    chk("t4_strobes", obs_val.size(), 5);
    chk("t4_fifth_val", obs_val[4], 32'h304);
    chk("t4_aborted", n_abt, 1);
    chk("t4_no_done", n_done, 0);
    chk("t4_word_count", word_count, 5);

    // Start while busy is ignored; reset mid-load clears silently.
    clear_obs();
    pulse_start();
    stream(6, 32'h400, 0, -1, 3, got);
    chk("t5_word_count_pre", word_count, 6);
    reset = 1'b1; cycle(); cycle(); reset = 1'b0;
    repeat (2) cycle();
    chk("t5_weightValue", weightValue, 0);
    chk("t5_layer", config_layer_num, 0);
    chk("t5_neuron", config_neuron_num, 0);
    chk("t5_word_count", word_count, 0);
    chk("t5_busy", busy, 0);
    chk("t5_no_pulses", n_done + n_abt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
